dir_ctrl: RTL and testbench

//  Upstream stage of the snake mover. Turns the four raw WASD push-buttons into the
//  2-bit heading the mover consumes. Synchronises and debounces each button, then detects

---
 rtl/snake_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 41 ++++
 rtl/dir_ctrl.sv | 102 ++++++++++
 tb/tb_dir_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake mover, display and direction control.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_LEFT  = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;
    localparam dir_t DIR_RESET = DIR_RIGHT;

    localparam int unsigned DEBOUNCE_CYC_DEF = 50000;
    localparam int unsigned CNT_W_DEF        = 16;

    // Opposite headings differ only in the upper bit of the encoding.
    function automatic logic is_reverse(dir_t x, dir_t y);
        return (x ^ y) == 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, hold-time debounce and press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after it has held long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dir_ctrl.sv
// WASD buttons to a committed heading; turns queue and commit on the mover's step strobe.
module dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w,
    input  logic       a,
    input  logic       s,
    input  logic       d,
    input  logic       move_tick,
    output logic [1:0] direction,
    output logic       turn_pend,
    output logic       turned,
    output logic       rejected
);

    logic rise_w;
    logic rise_a;
    logic rise_s;
    logic rise_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db_w (
        .clk(clk), .rst(rst), .btn(w), .rise(rise_w)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db_a (
        .clk(clk), .rst(rst), .btn(a), .rise(rise_a)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db_s (
        .clk(clk), .rst(rst), .btn(s), .rise(rise_s)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db_d (
        .clk(clk), .rst(rst), .btn(d), .rise(rise_d)
    );

    dir_t pending;
    dir_t req;
    logic req_vld;
    dir_t ref_dir;
    dir_t dir_n;
    dir_t pend_n;
    logic tp_n;
    logic turned_n;
    logic rej_n;

    // Fixed-priority pick among simultaneous presses: w > a > s > d.
    always_comb begin
        req_vld = rise_w | rise_a | rise_s | rise_d;
        req     = DIR_RIGHT;
        if (rise_w) begin
            req = DIR_UP;
        end else if (rise_a) begin
            req = DIR_LEFT;
        end else if (rise_s) begin
            req = DIR_DOWN;
        end
    end

    // Commit the old pending turn first, then judge any new press against the result.
    always_comb begin
        dir_n    = direction;
        pend_n   = pending;
        tp_n     = turn_pend;
        turned_n = 1'b0;
        rej_n    = 1'b0;
        if (move_tick && turn_pend) begin
            dir_n    = pending;
            tp_n     = 1'b0;
            turned_n = (pending != direction);
        end
        ref_dir = tp_n ? pend_n : dir_n;
        if (req_vld) begin
            if (is_reverse(req, ref_dir)) begin
                rej_n = 1'b1;
            end else if (req != ref_dir) begin
                pend_n = req;
                tp_n   = 1'b1;
            end
        end
    end

    // Heading, queued turn and event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            direction <= DIR_RESET;
            pending   <= DIR_RESET;
            turn_pend <= 1'b0;
            turned    <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            direction <= dir_n;
            pending   <= pend_n;
            turn_pend <= tp_n;
            turned    <= turned_n;
            rejected  <= rej_n;
        end
    end

endmodule

// File: tb/tb_dir_ctrl.sv
// Directed bench for dir_ctrl with a short debounce window.
module tb_dir_ctrl;

    localparam int unsigned DB = 8;

    logic       clk;
    logic       rst;
    logic       w;
    logic       a;
    logic       s;
    logic       d;
    logic       move_tick;
    logic [1:0] direction;
    logic       turn_pend;
    logic       turned;
    logic       rejected;

    int checks = 0;
    int errors = 0;

    dir_ctrl #(.DEBOUNCE_CYC(DB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .w(w), .a(a), .s(s), .d(d),
        .move_tick(move_tick),
        .direction(direction),
        .turn_pend(turn_pend),
        .turned(turned),
        .rejected(rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step(1);
        move_tick = 1'b0;
    endtask

    int n;
    int seen_tp;
    int seen_rej;

    initial begin
        rst = 1'b0; w = 1'b0; a = 1'b0; s = 1'b0; d = 1'b0; move_tick = 1'b0;

        // 1: reset values, then idle
        step(3);
        chk("rst_dir", direction, 3);
        chk("rst_tp", turn_pend, 0);
        chk("rst_turned", turned, 0);
        chk("rst_rej", rejected, 0);
        rst = 1'b1;
        seen_tp = 0; seen_rej = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (turn_pend || rejected || turned || direction != 2'd3) seen_tp++;
        end
        chk("idle_activity", seen_tp, 0);
        chk("idle_dir", direction, 3);

        // 2: press w -> pending within window, commit on tick
        w = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (turn_pend) begin n = i; break; end
        end
        chk("w_latency_ok", int'(n >= 10 && n <= 13), 1);
        chk("w_rej", rejected, 0);
        step(20 - n);
        w = 1'b0;
        step(15);
        chk("w_tp_held", turn_pend, 1);
        chk("w_dir_before", direction, 3);
        tick();
        chk("w_dir", direction, 0);
        chk("w_turned", turned, 1);
        chk("w_tp_clear", turn_pend, 0);
        step(1);
        chk("w_turned_1clk", turned, 0);

        // 3: reversal from right
        do_reset();
        chk("rev_dir0", direction, 3);
        a = 1'b1;
        seen_rej = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (rejected) begin seen_rej = i; break; end
        end
        chk("rev_rej_seen", int'(seen_rej != 0), 1);
        chk("rev_tp", turn_pend, 0);
        step(1);
        chk("rev_rej_1clk", rejected, 0);
        a = 1'b0;
        step(15);
        tick();
        chk("rev_dir", direction, 3);
        chk("rev_turned", turned, 0);

        // 4: bouncing s never debounces, then a steady hold does
        seen_tp = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) s = ~s;
            step(1);
            if (turn_pend || rejected) seen_tp++;
        end
        s = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (turn_pend || rejected) seen_tp++;
        end
        chk("bounce_quiet", seen_tp, 0);
        s = 1'b1;
        step(20);
        chk("s_tp", turn_pend, 1);
        s = 1'b0;
        step(15);
        tick();
        chk("s_dir", direction, 2);
        chk("s_turned", turned, 1);

        // 5: w and d together -> w wins; a then overwrites
        do_reset();
        w = 1'b1; d = 1'b1;
        step(20);
        w = 1'b0; d = 1'b0;
        chk("prio_tp", turn_pend, 1);
        step(15);
        seen_rej = 0;
        a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rejected) seen_rej++;
        end
        a = 1'b0;
        chk("ovr_rej", seen_rej, 0);
        chk("ovr_tp", turn_pend, 1);
        step(15);
        tick();
        chk("ovr_dir", direction, 1);

        // 6: press completes in the same clk as the tick, then async reset
        do_reset();
        w = 1'b1;
        step(20);
        w = 1'b0;
        step(15);
        chk("col_tp0", turn_pend, 1);
        a = 1'b1;
        step(DB + 2);
        chk("col_tp_pre", turn_pend, 1);
        chk("col_dir_pre", direction, 3);
        tick();
        chk("col_dir", direction, 0);
        chk("col_tp", turn_pend, 1);
        chk("col_turned", turned, 1);
        chk("col_rej", rejected, 0);
        step(3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_dir", direction, 3);
        chk("async_tp", turn_pend, 0);
        step(2);
        rst = 1'b1;
        // a still held: one fresh press, a reversal against right
        seen_rej = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rejected) seen_rej++;
        end
        chk("fresh_press_rej", seen_rej, 1);
        chk("fresh_tp", turn_pend, 0);
        a = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
